sync_fifo_flags: RTL and testbench
==================================

# sync_fifo_flags

Parametrised synchronous FIFO, the next generation of the team's basic `fifo` block. It adds the following over the basic block:
- configurable depth and width;
- full/empty and programmable almost-full/almost-empty status;
- an occupancy count;
- sticky overflow/underflow error flags;
- a synchronous flush;
- a selectable first-word-fall-through (FWFT) read mode.

It sits between single-clock producer/consumer stages as the standard buffering element.

## Interface
- DATA_WIDTH, 15, word width in bits
- DEPTH, 16, number of entries; power of two, ≥ 2
- ADDR_WIDTH, $clog2(DEPTH), pointer width (derived, not overridden)
- AF_THRESH, DEPTH-2, almost_full asserts when count ≥ AF_THRESH; legal range 1..DEPTH
- AE_THRESH, 2, almost_empty asserts when count ≤ AE_THRESH; legal range 0..DEPTH-1
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous flush
- wr_en  in  1  write request
- data_in  in  DATA_WIDTH  write data
- rd_en  in  1  read request (in FWFT mode this is a pop)
- data_out  out  DATA_WIDTH  read data
- full, almost_full, empty, almost_empty  out  1 each  status
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- overflow, underflow  out  1 each  sticky error flags

## Operation
- **Storage and pointers:** DEPTH-entry register array. Write pointer and read pointer are each ADDR_WIDTH+1 bits; the MSB is the wrap bit. Pointers wrap naturally at DEPTH.
- **Write acceptance:** wr_acc = wr_en & (!full | rd_acc).
  - A write to a full FIFO is accepted only when a read is accepted in the same cycle.
- **Read acceptance:** rd_acc = rd_en & !empty.
  - A read from an empty FIFO is always rejected, even when a write is accepted in the same cycle.
- **Count update:** count += wr_acc − rd_acc. When both are accepted, count is unchanged and the memory is written and read in the same cycle.
- **Status outputs:** combinational decodes of registered count:
  - full = (count == DEPTH)
  - empty = (count == 0)
  - almost_full = (count ≥ AF_THRESH)
  - almost_empty = (count ≤ AE_THRESH)
- **Error flags:**
  - overflow sets on wr_en & !wr_acc.
  - underflow sets on rd_en & empty.
  - Both remain set until clear or reset. A rejected access does not change pointers, count or data_out.
- **clear:** has priority over wr_en/rd_en in the same cycle.
  - Zeroes pointers, count, overflow, underflow, and the standard-mode data_out register.
  - Memory contents are not cleared.
- **Standard read mode (FWFT=0):** data_out is a register loaded with mem[rd_ptr] on rd_acc and holding otherwise.
- **FWFT read mode (FWFT=1):** data_out = empty ? 0 : mem[rd_ptr], combinationally. rd_acc advances to the next word.

## Timing
- **Reset values:** count 0, empty 1, almost_empty 1, full 0, almost_full 0, overflow 0, underflow 0, data_out 0.
- **Write to status:** a write at edge N is reflected in count and flags after edge N (status latency 1 cycle).
- **Standard-mode read latency:** data appears on data_out one cycle after the cycle in which rd_en is accepted.
- **FWFT latency:**
  - The first word written into an empty FIFO at edge N is visible on data_out after edge N.
  - After a pop at edge N, the next word is visible after edge N.
- **Reset mid-operation:** rst_n low at any time forces all reset values immediately, without waiting for clk.
- **Wrap-around:** after DEPTH writes and DEPTH reads, both pointers' wrap bits are toggled and the FIFO is empty. Behaviour across wraps is identical to the first pass.

## Structure
- Package `fifo_pkg` holds:
  - the default DATA_WIDTH and DEPTH constants;
  - a function that checks AF_THRESH/AE_THRESH legality, used in an elaboration-time assertion.
- Sub-module `fifo_mem`: DEPTH×DATA_WIDTH register array with one synchronous write port and one asynchronous read port. The top block contains only pointers, count, flags and the read-mode mux.

## Test plan
All scenarios use DATA_WIDTH=15, DEPTH=16, AF_THRESH=14, AE_THRESH=2.
1. **Reset and fill:** reset, then write 16 words 0x0001..0x0010.
   - almost_empty deasserts at count 3.
   - almost_full asserts at count 14.
   - full asserts at count 16.
   - A 17th write sets overflow, and count stays 16.
2. **Drain in standard mode (FWFT=0):** 16 reads return 0x0001..0x0010, each one cycle after its rd_en.
   - empty asserts after the last read.
   - A further read sets underflow, and data_out holds 0x0010.
3. **Simultaneous read/write at boundaries:**
   - At count 16, simultaneous rd_en+wr_en: count stays 16, no overflow, and the written word is returned 16 reads later.
   - At count 0, simultaneous rd_en+wr_en: read rejected, underflow set, count becomes 1.
4. **Wrap-around:** three full fill/drain cycles (48 words, 0x0100 upward). All data is returned in order, and count ends at 0.
5. **FWFT=1:** write 0x1234 into an empty FIFO; data_out shows 0x1234 the cycle after the write, before any rd_en. Pop: data_out returns to 0 and empty asserts.
6. **clear and mid-operation reset:**
   - At count 5 with overflow set, assert clear together with wr_en: count 0, flags 0, the write is ignored.
   - Drop rst_n between edges at count 7: outputs return to their reset values immediately.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared defaults and parameter-legality helpers for the sync_fifo_flags family.
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 15;
    localparam int DEF_DEPTH      = 16;

    // DEPTH must be a power of two >= 2 so the pointers can wrap naturally.
    // Thresholds must leave both almost flags reachable.
    function automatic bit thresh_legal(int depth, int af_thresh, int ae_thresh);
        bit depth_ok;
        depth_ok = (depth >= 2) && ((depth & (depth - 1)) == 0);
        return depth_ok
            && (af_thresh >= 1) && (af_thresh <= depth)
            && (ae_thresh >= 0) && (ae_thresh <= depth - 1);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH register array: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; occupancy tracking lives in the parent.
module fifo_mem #(
    parameter int DATA_WIDTH = 15,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Store the incoming word at the write address.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, full/empty and programmable almost flags,
// sticky overflow/underflow, synchronous flush and selectable FWFT read mode.
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2,
    parameter int FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  almost_full,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] FULL_CNT = CW'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_CNT   = CW'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] AE_CNT   = CW'(AE_THRESH);
    localparam logic [ADDR_WIDTH:0] ONE      = CW'(1);

    if (!thresh_legal(DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_params
        $fatal(1, "sync_fifo_flags: illegal DEPTH/AF_THRESH/AE_THRESH combination");
    end

    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [ADDR_WIDTH:0]   count_q;
    logic                  overflow_q;
    logic                  underflow_q;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] rd_data;

    assign count        = count_q;
    assign full         = (count_q == FULL_CNT);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_CNT);
    assign almost_empty = (count_q <= AE_CNT);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // A read never borrows from a same-cycle write; a write into a full FIFO
    // is only allowed when a read frees the slot in the same cycle.
    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | rd_acc);

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc & ~clear),
        .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
        .wr_data (data_in),
        .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
        .rd_data (rd_data)
    );

    // Pointers and occupancy; clear wins over any access in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + ONE;
            end
            if (wr_acc && !rd_acc) begin
                count_q <= count_q + ONE;
            end else if (rd_acc && !wr_acc) begin
                count_q <= count_q - ONE;
            end
        end
    end

    // Sticky error flags, only released by clear or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (clear) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_en && !wr_acc) begin
                overflow_q <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    if (FWFT == 0) begin : g_std_read
        logic [DATA_WIDTH-1:0] dout_q;

        // Registered read: capture the head word when a read is accepted.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dout_q <= '0;
            end else if (clear) begin
                dout_q <= '0;
            end else if (rd_acc) begin
                dout_q <= rd_data;
            end
        end

        assign data_out = dout_q;
    end else begin : g_fwft_read
        // Head word is presented directly; forced to zero while empty so stale
        // memory contents never leak out.
        assign data_out = empty ? '0 : rd_data;
    end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Self-checking bench: a standard-mode and an FWFT-mode instance share identical
// stimulus and are compared against a queue-based reference model.
module tb_sync_fifo_flags;

    localparam int DW = 15;
    localparam int DEPTH = 16;
    localparam int AF = 14;
    localparam int AE = 2;

    logic          clk;
    logic          rst_n;
    logic          clear;
    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] data_in;

    logic [DW-1:0] s_data_out, f_data_out;
    logic          s_full, s_af, s_empty, s_ae, s_ovf, s_unf;
    logic          f_full, f_af, f_empty, f_ae, f_ovf, f_unf;
    logic [4:0]    s_count, f_count;
    logic [10:0]   s_stat, f_stat;

    int total = 0;
    int bad = 0;

    // reference model
    logic [DW-1:0] q[$];
    bit            m_ovf, m_unf;
    logic [DW-1:0] m_dout_std;

    localparam logic [10:0] RESET_STAT = 11'b00000_0_0_1_1_0_0;

    sync_fifo_flags #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)
    ) u_std (
        .clk(clk), .rst_n(rst_n), .clear(clear), .wr_en(wr_en), .data_in(data_in),
        .rd_en(rd_en), .data_out(s_data_out), .full(s_full), .almost_full(s_af),
        .empty(s_empty), .almost_empty(s_ae), .count(s_count),
        .overflow(s_ovf), .underflow(s_unf)
    );

    sync_fifo_flags #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)
    ) u_fwft (
        .clk(clk), .rst_n(rst_n), .clear(clear), .wr_en(wr_en), .data_in(data_in),
        .rd_en(rd_en), .data_out(f_data_out), .full(f_full), .almost_full(f_af),
        .empty(f_empty), .almost_empty(f_ae), .count(f_count),
        .overflow(f_ovf), .underflow(f_unf)
    );

    assign s_stat = {s_count, s_full, s_af, s_empty, s_ae, s_ovf, s_unf};
    assign f_stat = {f_count, f_full, f_af, f_empty, f_ae, f_ovf, f_unf};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [10:0] exp_status();
        int n;
        n = q.size();
        return {5'(n), n == DEPTH, n >= AF, n == 0, n <= AE, m_ovf, m_unf};
    endfunction

    function automatic logic [DW-1:0] exp_fwft();
        return (q.size() > 0) ? q[0] : '0;
    endfunction

    task automatic model_reset();
        q.delete();
        m_ovf = 0;
        m_unf = 0;
        m_dout_std = '0;
    endtask

    // One clock: drive at negedge, update model at posedge, return at next negedge.
    task automatic step(input bit w, input bit r, input logic [DW-1:0] d, input bit c);
        bit full_now, empty_now, racc, wacc;
        wr_en = w;
        rd_en = r;
        data_in = d;
        clear = c;
        @(posedge clk);
        if (c) begin
            model_reset();
        end else begin
            full_now = (q.size() == DEPTH);
            empty_now = (q.size() == 0);
            racc = r && !empty_now;
            wacc = w && (!full_now || racc);
            if (w && !wacc) m_ovf = 1;
            if (r && empty_now) m_unf = 1;
            if (racc) m_dout_std = q.pop_front();
            if (wacc) q.push_back(d);
        end
        @(negedge clk);
        wr_en = 0;
        rd_en = 0;
        clear = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        clear = 0;
        wr_en = 0;
        rd_en = 0;
        data_in = '0;
        model_reset();
        @(negedge clk);
        total++;
        if (s_stat !== RESET_STAT) begin
            bad++; $display("FAIL reset_stat_std: got %b want %b", s_stat, RESET_STAT);
        end
        total++;
        if (f_stat !== RESET_STAT) begin
            bad++; $display("FAIL reset_stat_fwft: got %b want %b", f_stat, RESET_STAT);
        end
        total++;
        if ({s_data_out, f_data_out} !== '0) begin
            bad++; $display("FAIL reset_dout: got %h/%h want 0/0", s_data_out, f_data_out);
        end
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_fill();
        for (int i = 1; i <= DEPTH; i++) begin
            step(1, 0, DW'(i), 0);
            total++;
            if (s_stat !== exp_status()) begin
                bad++; $display("FAIL fill_stat[%0d]: got %b want %b", i, s_stat, exp_status());
            end
            total++;
            if ({s_ae, s_af, s_full} !== {i <= 2, i >= 14, i == 16}) begin
                bad++; $display("FAIL fill_flags[%0d]: got %b want %b", i, {s_ae, s_af, s_full},
                                {i <= 2, i >= 14, i == 16});
            end
            total++;
            if (f_data_out !== 15'h0001) begin
                bad++; $display("FAIL fill_fwft_head[%0d]: got %h want 0001", i, f_data_out);
            end
        end
        step(1, 0, 15'h7fff, 0);
        total++;
        if ({s_ovf, s_count} !== {1'b1, 5'd16}) begin
            bad++; $display("FAIL fill_overflow: got ovf=%b cnt=%0d want ovf=1 cnt=16", s_ovf, s_count);
        end
        total++;
        if (f_stat !== exp_status()) begin
            bad++; $display("FAIL fill_overflow_fwft: got %b want %b", f_stat, exp_status());
        end
    endtask

    task automatic test_drain_std();
        for (int i = 1; i <= DEPTH; i++) begin
            step(0, 1, '0, 0);
            total++;
            if (s_data_out !== DW'(i)) begin
                bad++; $display("FAIL drain_data[%0d]: got %h want %h", i, s_data_out, DW'(i));
            end
            total++;
            if (s_stat !== exp_status()) begin
                bad++; $display("FAIL drain_stat[%0d]: got %b want %b", i, s_stat, exp_status());
            end
            total++;
            if (f_data_out !== exp_fwft()) begin
                bad++; $display("FAIL drain_fwft[%0d]: got %h want %h", i, f_data_out, exp_fwft());
            end
        end
        total++;
        if (s_empty !== 1'b1) begin
            bad++; $display("FAIL drain_empty: got %b want 1", s_empty);
        end
        step(0, 1, '0, 0);
        total++;
        if ({s_unf, s_data_out} !== {1'b1, 15'h0010}) begin
            bad++; $display("FAIL drain_underflow: got unf=%b dout=%h want unf=1 dout=0010", s_unf, s_data_out);
        end
    endtask

    task automatic test_simul_boundary();
        logic [DW-1:0] x, y;
        step(0, 0, '0, 1);
        for (int i = 0; i < DEPTH; i++) step(1, 0, DW'($urandom), 0);
        x = DW'($urandom);
        step(1, 1, x, 0);
        total++;
        if ({s_count, s_ovf} !== {5'd16, 1'b0}) begin
            bad++; $display("FAIL simul_full: got cnt=%0d ovf=%b want cnt=16 ovf=0", s_count, s_ovf);
        end
        total++;
        if (s_data_out !== m_dout_std) begin
            bad++; $display("FAIL simul_full_dout: got %h want %h", s_data_out, m_dout_std);
        end
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 1, '0, 0);
            total++;
            if (s_data_out !== m_dout_std) begin
                bad++; $display("FAIL simul_drain[%0d]: got %h want %h", i, s_data_out, m_dout_std);
            end
        end
        total++;
        if (s_data_out !== x) begin
            bad++; $display("FAIL simul_last_word: got %h want %h", s_data_out, x);
        end
        y = DW'($urandom);
        step(1, 1, y, 0);
        total++;
        if ({s_count, s_unf} !== {5'd1, 1'b1}) begin
            bad++; $display("FAIL simul_empty: got cnt=%0d unf=%b want cnt=1 unf=1", s_count, s_unf);
        end
        total++;
        if (f_data_out !== y) begin
            bad++; $display("FAIL simul_empty_fwft: got %h want %h", f_data_out, y);
        end
        step(0, 0, '0, 1);
    endtask

    task automatic test_wrap();
        logic [DW-1:0] w;
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < DEPTH; k++) step(1, 0, DW'(16'h0100 + p * 16 + k), 0);
            for (int k = 0; k < DEPTH; k++) begin
                w = DW'(16'h0100 + p * 16 + k);
                step(0, 1, '0, 0);
                total++;
                if (s_data_out !== w) begin
                    bad++; $display("FAIL wrap_data[%0d.%0d]: got %h want %h", p, k, s_data_out, w);
                end
            end
        end
        total++;
        if ({s_count, s_empty, f_count, f_empty} !== {5'd0, 1'b1, 5'd0, 1'b1}) begin
            bad++; $display("FAIL wrap_end: got cnt=%0d/%0d empty=%b/%b want 0/0 1/1",
                            s_count, f_count, s_empty, f_empty);
        end
    endtask

    task automatic test_fwft();
        step(0, 0, '0, 1);
        step(1, 0, 15'h1234, 0);
        total++;
        if (f_data_out !== 15'h1234) begin
            bad++; $display("FAIL fwft_show: got %h want 1234", f_data_out);
        end
        total++;
        if (s_data_out !== 15'h0000) begin
            bad++; $display("FAIL fwft_std_idle: got %h want 0000", s_data_out);
        end
        step(0, 1, '0, 0);
        total++;
        if ({f_data_out, f_empty} !== {15'h0000, 1'b1}) begin
            bad++; $display("FAIL fwft_pop: got dout=%h empty=%b want 0000 1", f_data_out, f_empty);
        end
        total++;
        if (s_data_out !== 15'h1234) begin
            bad++; $display("FAIL fwft_std_read: got %h want 1234", s_data_out);
        end
    endtask

    task automatic test_clear();
        for (int i = 0; i < DEPTH; i++) step(1, 0, DW'($urandom), 0);
        step(1, 0, 15'h0abc, 0);
        for (int i = 0; i < 11; i++) step(0, 1, '0, 0);
        total++;
        if ({s_count, s_ovf} !== {5'd5, 1'b1}) begin
            bad++; $display("FAIL clear_setup: got cnt=%0d ovf=%b want cnt=5 ovf=1", s_count, s_ovf);
        end
        step(1, 0, 15'h2222, 1);
        total++;
        if (s_stat !== RESET_STAT) begin
            bad++; $display("FAIL clear_stat: got %b want %b", s_stat, RESET_STAT);
        end
        total++;
        if ({s_data_out, f_data_out} !== '0) begin
            bad++; $display("FAIL clear_dout: got %h/%h want 0/0", s_data_out, f_data_out);
        end
        total++;
        if (f_stat !== exp_status()) begin
            bad++; $display("FAIL clear_fwft_stat: got %b want %b", f_stat, exp_status());
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 7; i++) step(1, 1, DW'($urandom), 0);
        for (int i = 0; i < 6; i++) step(1, 0, DW'($urandom), 0);
        total++;
        if (s_count !== 5'd7) begin
            bad++; $display("FAIL midrst_setup: got cnt=%0d want 7", s_count);
        end
        #2;
        rst_n = 0;
        #1;
        model_reset();
        total++;
        if (s_stat !== RESET_STAT) begin
            bad++; $display("FAIL midrst_stat_std: got %b want %b", s_stat, RESET_STAT);
        end
        total++;
        if (f_stat !== RESET_STAT) begin
            bad++; $display("FAIL midrst_stat_fwft: got %b want %b", f_stat, RESET_STAT);
        end
        total++;
        if ({s_data_out, f_data_out} !== '0) begin
            bad++; $display("FAIL midrst_dout: got %h/%h want 0/0", s_data_out, f_data_out);
        end
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_random();
        bit w, r, c;
        int wbias;
        for (int i = 0; i < 800; i++) begin
            wbias = ((i / 100) % 2 == 0) ? 65 : 35;
            w = ($urandom_range(0, 99) < wbias);
            r = ($urandom_range(0, 99) < (100 - wbias));
            c = ($urandom_range(0, 63) == 0);
            step(w, r, DW'($urandom), c);
            total++;
            if (s_stat !== exp_status()) begin
                bad++; $display("FAIL rand_stat_std[%0d]: got %b want %b", i, s_stat, exp_status());
            end
            total++;
            if (f_stat !== exp_status()) begin
                bad++; $display("FAIL rand_stat_fwft[%0d]: got %b want %b", i, f_stat, exp_status());
            end
            total++;
            if (s_data_out !== m_dout_std) begin
                bad++; $display("FAIL rand_dout_std[%0d]: got %h want %h", i, s_data_out, m_dout_std);
            end
            total++;
            if (f_data_out !== exp_fwft()) begin
                bad++; $display("FAIL rand_dout_fwft[%0d]: got %h want %h", i, f_data_out, exp_fwft());
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain_std();
        test_simul_boundary();
        test_wrap();
        test_fwft();
        test_clear();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
